rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It generalises the 4:1 combinational mux in two ways: a run-time choice between software-fixed select and round-robin arbitration, and a single output register stage. It sits between several producer streams and one shared consumer, such as a shared bus, UART TX or memory port.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel, 1..64.
- SW = $clog2(N): derived select and channel-index width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready, combinational.
- mode  in  1  0 = fixed select by sel; 1 = round-robin.
- sel  in  SW  channel index used when mode = 0.
- out_data  out  W  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.
- out_ch  out  SW  index of the channel whose data is in out_data.

## Operation
- State:
  - output register: out_data, out_valid, out_ch.
  - round-robin pointer ptr (SW bits): the highest-priority channel for the next RR grant.
- Reset, asynchronous and immediate: out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is therefore 0 while rst=1.
- Load enable: load = !out_valid || out_ready.
- Grant, combinational:
  - mode=0: gnt_v = (sel < N) && in_valid[sel]; gnt = sel.
  - mode=1: gnt = first i with in_valid[i], scanning ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N); gnt_v = |in_valid.
- in_ready[i] = load && gnt_v && (gnt == i). At most one bit is set; every other channel sees 0.
- Clock edge, load && gnt_v:
  - out_data ← channel gnt; out_ch ← gnt; out_valid ← 1.
  - mode=1 only: ptr ← (gnt == N-1) ? 0 : gnt+1. mode=0 leaves ptr unchanged.
- Clock edge, load && !gnt_v: out_valid ← 0. out_data and out_ch hold their old values.
- Clock edge, !load (stalled): all output registers hold and ptr holds.
- Simultaneous output drain and refill in one cycle is allowed, giving full throughput.
- sel ≥ N (non-power-of-2 N) gives no grant, and all in_ready bits are 0.
- mode and sel are sampled every cycle. A change never alters data already held in the output register.

## Timing
- Latency: input transfer in cycle t → out_valid=1 with that data from cycle t+1.
- Throughput: 1 word/cycle while out_ready=1 and the granted channel stays valid.
- A transfer occurs when valid && ready are both high at a rising edge.
  - Inputs: in_valid[i] && in_ready[i].
  - Output: out_valid && out_ready.
- While out_valid=1 && out_ready=0: out_data and out_ch stay stable, and in_ready=0.
- Fairness in mode=1: with all N channels continuously valid, each channel is granted exactly once in every N consecutive transfers.
- in_ready depends combinationally on in_valid, mode, sel, out_ready and registered state. in_valid must not depend combinationally on in_ready.
- Deasserting rst takes effect at the next clk edge. A word held in the output register when reset asserts is discarded.

## Test plan
- Reset:
  - Stimulus: assert rst mid-stream with out_valid=1.
  - Required: out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately, before the next clk edge.
  - After release, with mode=1 and all channels valid, the first grant is ch0.
- Fixed select:
  - Stimulus: N=4, W=8, mode=0, sel=2, all valid, in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, out_ready=1.
  - Required: out_data=8'hC2 and out_ch=2 one cycle later; in_ready=4'b0100; ptr unchanged.
  - Then set sel=3 with in_valid[3]=0: in_ready=0, and out_valid falls on the next edge.
- Round-robin wrap:
  - Stimulus: mode=1, in_valid=4'b1111 held, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
  - Then in_valid=4'b1001 with ptr=1: grant order 3, 0, 3, 0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while valid output 8'h5A is held.
  - Required: out_data=8'h5A and out_ch stable, in_ready=0 for those cycles.
  - Raise out_ready: a drain and a new load occur in the same cycle, with no bubble.
- Idle and sparse traffic:
  - Stimulus: in_valid=0.
  - Required: out_valid drops after the pending word drains.
  - Then a single pulse on ch2 (data 8'h77): exactly one output beat of 8'h77 with out_ch=2.
- Non-power-of-2:
  - Stimulus: N=3, mode=0, sel=3.
  - Required: in_ready=3'b000 and out_valid stays 0.
  - mode=1 with all valid: out_ch cycles 0,1,2,0.

Source files
------------

// File: rtl/rr_mux_n.sv
// N-channel W-bit registered mux with valid/ready on every port; fixed-select or round-robin grant.
// One cycle latency, full throughput; in_ready is combinational and drops while the output stalls.
module rr_mux_n #(
    parameter int N  = 4,
    parameter int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_ch
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load;
    logic          gnt_v;
    logic [SW-1:0] gnt;
    logic [W-1:0]  gnt_data;
    logic          rr_found;
    logic [SW-1:0] rr_gnt;
    int            idx;

    assign load = !out_valid_q || out_ready;

    // Round-robin scan starts at ptr and wraps modulo N.
    always_comb begin
        rr_found = 1'b0;
        rr_gnt   = '0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!rr_found && in_valid[idx[SW-1:0]]) begin
                rr_found = 1'b1;
                rr_gnt   = idx[SW-1:0];
            end
        end
    end

    // Fixed select: an index beyond N-1 matches no channel and grants nothing.
    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        if (mode) begin
            gnt   = rr_gnt;
            gnt_v = rr_found;
        end else begin
            gnt = sel;
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) gnt_v = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SW'(i)) gnt_data = in_data[i*W +: W];
            in_ready[i] = !rst && load && gnt_v && (gnt == SW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_v;
            if (gnt_v) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt;
                if (mode) ptr_d = (gnt == SW'(N-1)) ? '0 : gnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: a 4-channel instance checked against a reference model and beat
// scoreboard, plus a 3-channel instance for the non-power-of-2 select range.
module tb_rr_mux_n;

    logic clk;
    logic rst;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4, out_valid4, out_ready4;
    logic [1:0]  sel4, out_ch4;
    logic [7:0]  out_data4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3, out_valid3, out_ready3;
    logic [1:0]  sel3, out_ch3;
    logic [7:0]  out_data3;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } beat_t;

    beat_t    sb_q[$];
    logic [1:0] m_ptr;
    int       n_checks = 0;
    int       n_err    = 0;

    rr_mux_n #(.N(4), .W(8)) u4 (
        .clk(clk), .rst(rst),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4), .sel(sel4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4), .out_ch(out_ch4)
    );

    rr_mux_n #(.N(3), .W(8)) u3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick(input string tag);
        logic [1:0] g;
        logic       gv;
        logic       ld;
        logic       found;
        logic [1:0] ix;
        beat_t      b;
        #1;
        g  = 2'd0;
        gv = 1'b0;
        if (!mode4) begin
            g  = sel4;
            gv = in_valid4[sel4];
        end else begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                ix = m_ptr + 2'(k);
                if (!found && in_valid4[ix]) begin
                    found = 1'b1;
                    g     = ix;
                end
            end
            gv = found;
        end
        ld = (sb_q.size() == 0) || out_ready4;
        chk({tag, "_in_ready"}, 64'(in_ready4), 64'((ld && gv) ? (4'b0001 << g) : 4'b0000));
        chk({tag, "_out_valid"}, 64'(out_valid4), 64'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            b = sb_q[0];
            chk({tag, "_out_data"}, 64'(out_data4), 64'(b.d));
            chk({tag, "_out_ch"}, 64'(out_ch4), 64'(b.ch));
            if (out_ready4) void'(sb_q.pop_front());
        end
        if (ld && gv) begin
            b.d  = in_data4[g*8 +: 8];
            b.ch = g;
            sb_q.push_back(b);
            if (mode4) m_ptr = (g == 2'd3) ? 2'd0 : g + 2'd1;
        end
        @(negedge clk);
    endtask

    logic [1:0] rr_exp [0:8];

    initial begin
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
        rst = 1'b0;
        in_data4 = 32'hD3C2B1A0; in_valid4 = 4'hF; mode4 = 1'b1; sel4 = 2'd0; out_ready4 = 1'b1;
        in_data3 = 24'h626160;   in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        m_ptr = 2'd0;
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready4), 64'h0);
        chk("rst_out_valid", 64'(out_valid4), 64'h0);
        chk("rst_out_data", 64'(out_data4), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fixed select of channel 2
        mode4 = 1'b0; sel4 = 2'd2;
        tick("fix_sel2");
        chk("fix_data", 64'(out_data4), 64'hC2);
        chk("fix_ch", 64'(out_ch4), 64'd2);
        sel4 = 2'd3; in_valid4 = 4'b0111;
        tick("fix_sel3_invalid");
        chk("fix_drop_valid", 64'(out_valid4), 64'h0);
        tick("fix_idle");

        // Round-robin wrap, then a sparse pattern from ptr=1
        mode4 = 1'b1; in_valid4 = 4'hF;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) in_valid4 = 4'b1001;
            tick("rr");
            chk($sformatf("rr_ch_%0d", i), 64'(out_ch4), 64'(rr_exp[i]));
        end

        // Backpressure on a held 8'h5A
        mode4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'hF; in_data4 = 32'h33225A11;
        tick("bp_load");
        out_ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("bp_stall");
            chk("bp_hold_data", 64'(out_data4), 64'h5A);
            chk("bp_hold_ch", 64'(out_ch4), 64'd1);
            chk("bp_hold_ready", 64'(in_ready4), 64'h0);
        end
        in_data4 = 32'h33226B11; out_ready4 = 1'b1;
        tick("bp_release");
        chk("bp_no_bubble_valid", 64'(out_valid4), 64'h1);
        chk("bp_no_bubble_data", 64'(out_data4), 64'h6B);

        // Idle, then a single pulse on channel 2
        in_valid4 = 4'h0;
        tick("idle_drain");
        chk("idle_valid", 64'(out_valid4), 64'h0);
        mode4 = 1'b1; in_valid4 = 4'b0100; in_data4 = 32'h33776B11;
        tick("pulse_load");
        in_valid4 = 4'h0;
        chk("pulse_data", 64'(out_data4), 64'h77);
        chk("pulse_ch", 64'(out_ch4), 64'd2);
        tick("pulse_drain");
        chk("pulse_single", 64'(out_valid4), 64'h0);
        tick("pulse_idle");

        // Asynchronous reset with a word held
        in_valid4 = 4'hF;
        tick("mid_load");
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid4), 64'h0);
        chk("arst_data", 64'(out_data4), 64'h0);
        chk("arst_ch", 64'(out_ch4), 64'h0);
        chk("arst_in_ready", 64'(in_ready4), 64'h0);
        sb_q.delete();
        m_ptr = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        tick("post_rst");
        chk("post_rst_ch", 64'(out_ch4), 64'd0);
        in_valid4 = 4'h0;
        tick("post_rst_drain");

        // Three channels: out-of-range select, then round-robin
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        chk("n3_sel3_ready", 64'(in_ready3), 64'h0);
        @(negedge clk);
        chk("n3_sel3_valid_a", 64'(out_valid3), 64'h0);
        @(negedge clk);
        chk("n3_sel3_valid_b", 64'(out_valid3), 64'h0);
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("n3_rr_ready_%0d", i), 64'(in_ready3), 64'(3'b001 << (i % 3)));
            @(negedge clk);
            chk($sformatf("n3_rr_ch_%0d", i), 64'(out_ch3), 64'(i % 3));
            chk($sformatf("n3_rr_data_%0d", i), 64'(out_data3), 64'(8'h60 + (i % 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
